// File: rtl/pio_pkg.sv
// Shared register map and mode encodings for the edge-capturing PIO input port.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser with per-bit edge detection, held off while the chain fills after reset.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] data_s,
  output logic [DATA_WIDTH-1:0] edge_v
);

  localparam int PRIME_N = SYNC_STAGES + 1;
  localparam int CNT_W   = $clog2(PRIME_N + 1);

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q, sync_d;
  logic [DATA_WIDTH-1:0]                  prev_q, prev_d;
  logic [CNT_W-1:0]                       prime_q, prime_d;
  logic                                   primed;
  logic [DATA_WIDTH-1:0]                  edge_raw;

  assign data_s = sync_q[SYNC_STAGES-1];
  // Inputs static at reset would otherwise look like edges while the chain fills.
  assign primed = (prime_q == CNT_W'(PRIME_N));

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], in_port};
    prev_d  = data_s;
    prime_d = primed ? prime_q : prime_q + 1'b1;
    case (EDGE_TYPE)
      EDGE_FALL: edge_raw = ~data_s & prev_q;
      EDGE_ANY:  edge_raw = data_s ^ prev_q;
      default:   edge_raw = data_s & ~prev_q;
    endcase
    edge_v = primed ? edge_raw : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev_q  <= '0;
      prime_q <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      prime_q <= prime_d;
    end
  end

endmodule

// File: rtl/soc_system_pio_in_edge_irq.sv
// Avalon-MM input PIO: synchronised data, interrupt mask and W1C edge-capture register.
module soc_system_pio_in_edge_irq
  import pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int IRQ_MODE    = IRQ_EDGE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] data_s, edge_v;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
  logic [DATA_WIDTH-1:0] clr;
  logic [31:0]           readdata_q, readdata_d;
  logic                  irq_q, irq_d;
  logic                  wr_en;
  logic                  unused_wdata;

  pio_sync_edge #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .data_s  (data_s),
    .edge_v  (edge_v)
  );

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;
  assign readdata     = readdata_q;
  assign irq          = irq_q;

  always_comb begin
    mask_d     = mask_q;
    clr        = '0;
    readdata_d = '0;
    if (wr_en && address == ADDR_MASK) mask_d = writedata[DATA_WIDTH-1:0];
    if (wr_en && address == ADDR_EDGE) clr = writedata[DATA_WIDTH-1:0];
    // A new edge in the same cycle as its clear must not be lost.
    edgecap_d = (edgecap_q & ~clr) | edge_v;
    case (address)
      ADDR_DATA: readdata_d[DATA_WIDTH-1:0] = data_s;
      ADDR_RSVD: readdata_d = '0;
      ADDR_MASK: readdata_d[DATA_WIDTH-1:0] = mask_q;
      default:   readdata_d[DATA_WIDTH-1:0] = edgecap_q;
    endcase
    if (IRQ_MODE == IRQ_LEVEL) irq_d = |(data_s & mask_q);
    else                       irq_d = |(edgecap_q & mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_soc_system_pio_in_edge_irq.sv
// Directed bench: an edge-IRQ instance and a level-IRQ instance share one bus and in_port.
module tb_soc_system_pio_in_edge_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata_e, readdata_l;
  logic        irq_e, irq_l;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  soc_system_pio_in_edge_irq #(
    .DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1)
  ) u_dut_edge (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_e),
    .in_port(in_port), .irq(irq_e)
  );

  soc_system_pio_in_edge_irq #(
    .DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(0)
  ) u_dut_level (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_l),
    .in_port(in_port), .irq(irq_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    write_n    = 1'b1;
    chipselect = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b1;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'hFF;

    // reset with inputs high
    tick(3);
    check("rst_readdata", readdata_e, 32'h0);
    check("rst_irq_e", {31'b0, irq_e}, 32'h0);
    reset_n = 1'b1;
    tick();
    check("rst_rd_data", readdata_e, 32'h0);
    rd(2'd1); check("rst_rd_rsvd", readdata_e, 32'h0);
    rd(2'd2); check("rst_rd_mask", readdata_e, 32'h0);
    rd(2'd3); check("rst_rd_edge", readdata_e, 32'h0);
    check("rst_irq_e2", {31'b0, irq_e}, 32'h0);
    tick(10);
    rd(2'd3); check("prime_no_edge", readdata_e, 32'h0);
    rd(2'd0); check("static_data_ff", readdata_e, 32'hFF);

    // falling edges are ignored in rising mode
    in_port = 8'h00;
    tick(5);
    rd(2'd3); check("fall_ignored", readdata_e, 32'h0);

    // rising 0x00 -> 0x81, latency of edge and level irq
    wr(2'd2, 32'h80);
    rd(2'd2); check("mask_rb", readdata_e, 32'h80);
    in_port = 8'h81;
    tick(2);
    check("lvl_irq_k2", {31'b0, irq_l}, 32'h0);
    check("edge_irq_k2", {31'b0, irq_e}, 32'h0);
    tick();
    check("lvl_irq_k3", {31'b0, irq_l}, 32'h1);
    check("edge_irq_k3", {31'b0, irq_e}, 32'h0);
    tick();
    check("edge_irq_k4", {31'b0, irq_e}, 32'h1);
    rd(2'd3); check("edgecap_81", readdata_e, 32'h81);
    wr(2'd3, 32'h01);
    rd(2'd3); check("edgecap_clr0", readdata_e, 32'h80);
    check("irq_hold_80", {31'b0, irq_e}, 32'h1);

    // clearing bit 7 drops irq two clocks after the write is presented
    wr(2'd3, 32'h80);
    check("irq_clr_1clk", {31'b0, irq_e}, 32'h1);
    tick();
    check("irq_clr_2clk", {31'b0, irq_e}, 32'h0);
    rd(2'd3); check("edgecap_empty", readdata_e, 32'h0);

    // data read latency
    in_port = 8'hA5;
    tick(3);
    rd(2'd0); check("data_a5", readdata_e, 32'h0000_00A5);
    rd(2'd3); check("edgecap_24", readdata_e, 32'h24);

    // set wins over a simultaneous clear
    in_port = 8'hA4;
    tick(4);
    wr(2'd3, 32'hFF);
    rd(2'd3); check("edgecap_clr_all", readdata_e, 32'h0);
    wr(2'd2, 32'h01);
    in_port = 8'hA5;
    tick(4);
    check("bit0_irq", {31'b0, irq_e}, 32'h1);
    in_port = 8'hA4;
    tick(3);
    in_port = 8'hA5;
    tick(2);
    wr(2'd3, 32'h01);
    check("race_irq_a", {31'b0, irq_e}, 32'h1);
    rd(2'd3); check("race_edgecap", readdata_e, 32'h01);
    check("race_irq_b", {31'b0, irq_e}, 32'h1);

    // mid-operation reset wipes everything at once
    reset_n = 1'b0;
    #1;
    check("midrst_readdata", readdata_e, 32'h0);
    check("midrst_irq", {31'b0, irq_e}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(5);
    rd(2'd2); check("midrst_mask", readdata_e, 32'h0);
    rd(2'd3); check("midrst_edgecap", readdata_e, 32'h0);

    // level mode and read-only / reserved registers
    wr(2'd2, 32'hFFFF_FF04);
    rd(2'd2); check("mask_upper_zero", readdata_l, 32'h04);
    in_port = 8'h00;
    tick(4);
    check("lvl_idle", {31'b0, irq_l}, 32'h0);
    in_port = 8'h04;
    tick(2);
    check("lvl_rise_k2", {31'b0, irq_l}, 32'h0);
    tick();
    check("lvl_rise_k3", {31'b0, irq_l}, 32'h1);
    in_port = 8'h0B;
    tick(2);
    check("lvl_fall_k2", {31'b0, irq_l}, 32'h1);
    tick();
    check("lvl_fall_k3", {31'b0, irq_l}, 32'h0);
    wr(2'd0, 32'hFF);
    wr(2'd1, 32'hFF);
    rd(2'd0); check("data_ro", readdata_l, 32'h0B);
    rd(2'd1); check("rsvd_zero", readdata_l, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
